// File: rtl/multi_dataflow_job_ctrl.sv
// Job sequencer for multi-dataflow HWPEs: queues job descriptors, applies each job's
// dataflow config, launches every stream with its own length, counts per-stream
// handshakes and raises a one-hot done event to the offloading core.
module multi_dataflow_job_ctrl #(
  parameter int unsigned N_IN      = 2,
  parameter int unsigned N_OUT     = 1,
  parameter int unsigned N_CONTEXT = 2,
  parameter int unsigned N_CORES   = 2,
  parameter int unsigned CNT_W     = 16,
  parameter int unsigned CFG_W     = 32
) (
  input  logic                                               clk_i,
  input  logic                                               rst_i,
  input  logic                                               job_push_i,
  input  logic [CFG_W-1:0]                                   job_cfg_i,
  input  logic [N_IN*CNT_W-1:0]                              job_in_len_i,
  input  logic [N_OUT*CNT_W-1:0]                             job_out_len_i,
  input  logic [((N_CORES > 1) ? $clog2(N_CORES) : 1)-1:0]   job_core_i,
  input  logic                                               abort_i,
  input  logic [N_IN-1:0]                                    in_hs_i,
  input  logic [N_OUT-1:0]                                   out_hs_i,
  output logic                                               job_ready_o,
  output logic                                               busy_o,
  output logic [CFG_W-1:0]                                   cfg_o,
  output logic                                               cfg_load_o,
  output logic [N_IN-1:0]                                    in_req_o,
  output logic [N_IN*CNT_W-1:0]                              in_len_o,
  output logic [N_OUT-1:0]                                   out_req_o,
  output logic [N_OUT*CNT_W-1:0]                             out_len_o,
  output logic [N_CORES-1:0]                                 evt_o,
  output logic                                               overrun_o
);

  localparam int unsigned NS    = N_IN + N_OUT;
  localparam int unsigned PtrW  = (N_CONTEXT > 1) ? $clog2(N_CONTEXT) : 1;
  localparam int unsigned CntW  = $clog2(N_CONTEXT + 1);
  localparam int unsigned CoreW = (N_CORES > 1) ? $clog2(N_CORES) : 1;

  typedef enum logic [2:0] {StIdle, StLoad, StStart, StRun, StDone} state_e;

  state_e state_q, state_d;

  // Descriptor storage; the active job stays at the head until DONE or abort.
  logic [CFG_W-1:0]    cfg_mem  [N_CONTEXT];
  logic [NS*CNT_W-1:0] len_mem  [N_CONTEXT];
  logic [CoreW-1:0]    core_mem [N_CONTEXT];

  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            push_acc, pop;

  logic [CFG_W-1:0]    cfg_q, head_cfg;
  logic [NS*CNT_W-1:0] head_len;
  logic [CoreW-1:0]    head_core;

  logic [CNT_W-1:0] len_s [NS];
  logic [CNT_W-1:0] cnt_q [NS];
  logic [CNT_W-1:0] cnt_d [NS];
  logic [NS-1:0]    done_q, done_d, hs, req;
  logic             overrun_q, overrun_d;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(N_CONTEXT - 1)) ? '0 : p + PtrW'(1);
  endfunction

  assign job_ready_o = (count_q < CntW'(N_CONTEXT));
  assign push_acc    = job_push_i & job_ready_o;
  // The head leaves the queue on completion or on abort of an active job.
  assign pop         = (state_q == StDone) | (abort_i & (state_q != StIdle));

  assign head_cfg  = cfg_mem[rd_ptr_q];
  assign head_len  = len_mem[rd_ptr_q];
  assign head_core = core_mem[rd_ptr_q];
  assign hs        = {out_hs_i, in_hs_i};

  // Queue pointer and occupancy next-state.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_acc) begin
      wr_ptr_d = ptr_inc(wr_ptr_q);
      count_d  = count_d + CntW'(1);
    end
    if (pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
      count_d  = count_d - CntW'(1);
    end
  end

  // Per-stream counters, done flags, start pulses and overrun detection.
  always_comb begin
    done_d    = done_q;
    overrun_d = overrun_q;
    req       = '0;
    for (int k = 0; k < NS; k++) begin
      len_s[k] = head_len[k*CNT_W +: CNT_W];
      cnt_d[k] = cnt_q[k];
    end
    if (state_q == StStart) begin
      for (int k = 0; k < NS; k++) begin
        cnt_d[k]  = '0;
        done_d[k] = (len_s[k] == '0);
        req[k]    = (len_s[k] != '0);
      end
    end else if (state_q == StRun) begin
      for (int k = 0; k < NS; k++) begin
        if (hs[k]) begin
          if (done_q[k]) begin
            overrun_d = 1'b1;
          end else begin
            cnt_d[k] = cnt_q[k] + CNT_W'(1);
            if (cnt_d[k] == len_s[k]) done_d[k] = 1'b1;
          end
        end
      end
    end
    if ((state_q != StRun) && (|hs)) overrun_d = 1'b1;
  end

  // FSM next-state; an abort of an active job always wins.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (count_d != '0) state_d = StLoad;
      StLoad:  state_d = StStart;
      StStart: state_d = (&done_d) ? StDone : StRun;
      StRun:   if (&done_d) state_d = StDone;
      StDone:  state_d = (count_d != '0) ? StLoad : StIdle;
      default: state_d = StIdle;
    endcase
    if (abort_i && (state_q != StIdle)) state_d = StIdle;
  end

  // Outputs decoded from state and head descriptor.
  always_comb begin
    busy_o     = (state_q != StIdle);
    cfg_load_o = (state_q == StLoad);
    cfg_o      = (state_q == StLoad) ? head_cfg : cfg_q;
    in_req_o   = req[N_IN-1:0];
    out_req_o  = req[NS-1:N_IN];
    in_len_o   = busy_o ? head_len[N_IN*CNT_W-1:0] : '0;
    out_len_o  = busy_o ? head_len[NS*CNT_W-1:N_IN*CNT_W] : '0;
    overrun_o  = overrun_q;
    evt_o      = '0;
    if ((state_q == StDone) && !abort_i) evt_o[head_core] = 1'b1;
  end

  // Descriptor memory write; contents are don't-care until pushed.
  always_ff @(posedge clk_i) begin
    if (push_acc) begin
      cfg_mem[wr_ptr_q]  <= job_cfg_i;
      len_mem[wr_ptr_q]  <= {job_out_len_i, job_in_len_i};
      core_mem[wr_ptr_q] <= job_core_i;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      cfg_q     <= '0;
      done_q    <= '0;
      overrun_q <= 1'b0;
      for (int k = 0; k < NS; k++) cnt_q[k] <= '0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      done_q    <= done_d;
      overrun_q <= overrun_d;
      if (state_q == StLoad) cfg_q <= head_cfg;
      for (int k = 0; k < NS; k++) cnt_q[k] <= cnt_d[k];
    end
  end

endmodule
